// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: hunts for a sliding sync pattern, then assembles
// FRAME_WORDS MSB-first words per frame into a small output FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HUNT     | shifting consumed bits through sr looking for SYNC_WORD
// ASSEMBLE | collecting FRAME_WORDS data words of the locked frame
module serial_deser #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hA5,
    parameter int               FRAME_WORDS = 4,
    parameter int               FIFO_DEPTH  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_start,
    output logic             locked,
    output logic             overflow
);

    localparam int BW = $clog2(WIDTH);
    localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic {HUNT, ASSEMBLE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word_sr;
    logic [BW-1:0]    bit_cnt;
    logic [WW-1:0]    word_cnt;

    logic [WIDTH:0]   mem [0:FIFO_DEPTH-1];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             din_bit;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] word_next;
    logic             push;
    logic             pop;
    logic             full;
    logic             do_write;

    // An unknown serial bit must resolve to 0, so only an explicit 1 is taken as 1.
    always_comb begin
        din_bit = 1'b0;
        if (din)
            din_bit = 1'b1;
    end

    always_comb begin
        sr_next   = {sr[WIDTH-2:0], din_bit};
        word_next = {word_sr[WIDTH-2:0], din_bit};
        push      = (state == ASSEMBLE) && din_valid && (bit_cnt == BIT_LAST);
        pop       = (count != '0) && dout_ready;
        full      = (count == CNT_FULL);
        do_write  = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HUNT;
            sr       <= '0;
            word_sr  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (din_valid) begin
                if (state == HUNT) begin
                    sr <= sr_next;
                    if (sr_next == SYNC_WORD) begin
                        state    <= ASSEMBLE;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end else begin
                    word_sr <= word_next;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (word_cnt == WORD_LAST) begin
                            state    <= HUNT;
                            sr       <= '0;
                            word_cnt <= '0;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end

            // A full FIFO still accepts the word if the head leaves on the same edge.
            if (do_write) begin
                mem[wr_ptr] <= {(word_cnt == '0), word_next};
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;

            if (do_write && !pop)
                count <= count + 1'b1;
            else if (!do_write && pop)
                count <= count - 1'b1;

            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    assign dout        = mem[rd_ptr][WIDTH-1:0];
    assign frame_start = mem[rd_ptr][WIDTH];
    assign dout_valid  = (count != '0);
    assign locked      = (state == ASSEMBLE);

endmodule

// File: doc/serial_deser.md
SERIAL_DESER -- requirements
Module: serial_deser

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits.
REQ-002 Parameter: SYNC_WORD, 8'hA5, WIDTH-bit frame sync pattern.
REQ-003 Parameter: FRAME_WORDS, 4, data words per frame after sync (>=1).
REQ-004 Parameter: FIFO_DEPTH, 2, output buffer entries (>=1).
REQ-005 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-006 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-007 Port: din  input  1  serial bit from the upstream flop stage, MSB-first.
REQ-008 Port: din_valid  input  1  din qualifier; a bit is consumed only on an edge where din_valid=1.
REQ-009 Port: dout  output  WIDTH  assembled data word at FIFO head.
REQ-010 Port: dout_valid  output  1  FIFO non-empty.
REQ-011 Port: dout_ready  input  1  consumer accept; pop on edge with dout_valid=1 and dout_ready=1.
REQ-012 Port: frame_start  output  1  head word is first word of its frame; meaningful only when dout_valid=1.
REQ-013 Port: locked  output  1  1 while in ASSEMBLE state.
REQ-014 Port: overflow  output  1  sticky; word dropped because FIFO full.

Function
REQ-015 din of X/Z on a consumed edge SHALL be treated as 0.
REQ-016 States SHALL be HUNT and ASSEMBLE only.
REQ-017 HUNT: each consumed bit SHALL shift into WIDTH-bit sync register, sr <= {sr[WIDTH-2:0], din}.
REQ-018 HUNT: if the post-shift value equals SYNC_WORD, SHALL go to ASSEMBLE on that edge, bit_cnt=0, word_cnt=0; next consumed bit is data MSB.
REQ-019 Sync search SHALL be sliding (every bit position), no word alignment assumed before lock.
REQ-020 ASSEMBLE: each consumed bit SHALL shift into word register MSB-first, bit_cnt increments.
REQ-021 On the edge consuming bit WIDTH-1, completed word SHALL be pushed to FIFO (with frame_start=1 iff word_cnt=0), bit_cnt wraps to 0, word_cnt increments.
REQ-022 Push latency: dout_valid/dout SHALL reflect a word pushed into an empty FIFO in the cycle after the push edge (1 cycle).
REQ-023 After word FRAME_WORDS-1 is completed, SHALL return to HUNT on that edge, sr cleared to 0; locked=0 from next cycle.
REQ-024 din_valid=0: no change to sr, word register, bit_cnt, word_cnt or state.
REQ-025 FIFO: in-order, FIFO_DEPTH entries of {frame_start, word}; dout/frame_start stable while dout_valid=1 and dout_ready=0.
REQ-026 Push when full with no pop same edge: word SHALL be dropped, overflow set to 1, word still counted toward FRAME_WORDS.
REQ-027 Push and pop on same edge when full: both SHALL occur; no drop, overflow unchanged.
REQ-028 Push and pop on same edge when empty: word SHALL be stored (no bypass); dout_valid=1 next cycle.
REQ-029 overflow SHALL remain 1 until reset.

Reset
REQ-030 reset=1 on an edge SHALL force HUNT, sr=0, word register=0, bit_cnt=0, word_cnt=0, FIFO empty, overflow=0; reset has priority over all inputs.
REQ-031 From the cycle after reset: dout_valid=0, dout=0, frame_start=0, locked=0, overflow=0.
REQ-032 Reset mid-frame SHALL discard partial word and all buffered words; a new SYNC_WORD is required before data is accepted.

Verification
REQ-033 Hold reset 2 cycles with din_valid=1, din=1 -> dout_valid=0, locked=0, overflow=0 afterwards.
REQ-034 dout_ready=1; bits A5,3C,11,22,33 (MSB-first, din_valid=1) -> dout 3C(frame_start=1),11,22,33 each 1 cycle after last bit; locked high from bit 8 edge to bit 40 edge.
REQ-035 Stream 1,0,1,0,0,1,0,0 then A5,3C,... -> no lock on A4; lock only after full A5 match; first word 3C.
REQ-036 dout_ready=0 for whole frame A5,3C,11,22,33 -> dout_valid=1, dout=3C held, 11 second entry, 22/33 dropped, overflow=1; then dout_ready=1 -> 3C,11 then empty.
REQ-037 Same frame with din_valid randomly low ~50% and din=X on gap cycles -> identical output words; one X on a consumed data bit (3C MSB) -> 3C.
REQ-038 Reset asserted after 12 data bits of a frame -> FIFO empty, locked=0; subsequent frame without A5 produces no output.
